mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative 24-bit unsigned multiply/divide unit in the execute stage of the 24-bit CPU.
- Consumes the register file's two read-port values (ReadRS/ReadRT) as operands.
- Produces a write-back triple (data, destination register, write strobe) that drives the register file's WriteData/RD/RegWrite path through the write-back mux.
- Used for MUL, MULH, DIV and REM instructions; the control unit stalls the pipeline while Busy is high.

Parameters:
- WIDTH, 24, operand and result width in bits.
- REG_ADDR_W, 4, register address width (16 registers).

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a new operation; sampled only in IDLE.
- Op  input  2  operation: 00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM (remainder).
- OperandA  input  WIDTH  multiplicand or dividend (from ReadRS).
- OperandB  input  WIDTH  multiplier or divisor (from ReadRT).
- DestReg  input  REG_ADDR_W  destination register (RD) captured with Start.
- Busy  output  1  high from the cycle after acceptance through the DONE cycle.
- Done  output  1  one-cycle pulse when Result is valid.
- Result  output  WIDTH  final result; held until the next accepted Start.
- ResultReg  output  REG_ADDR_W  captured DestReg; held with Result.
- ResultWrite  output  1  one-cycle register-file write strobe, coincident with Done.

Behaviour:
- Clock/reset: one clock, Clock; reset is synchronous and active-high, Reset.
- Reset state: state = IDLE; Busy, Done, ResultWrite = 0; Result = 0; ResultReg = 0; internal counter, accumulators and latched operands = 0.
- FSM states:
  - IDLE: if Start, latch OperandA, OperandB, Op and DestReg, clear accumulators, load counter = WIDTH-1, go to COMPUTE. Otherwise stay.
  - COMPUTE: one iteration per cycle, exactly WIDTH (24) cycles. When counter = 0, go to DONE; otherwise decrement the counter.
  - DONE: one cycle, registered outputs Done = ResultWrite = 1, Result/ResultReg updated; then go to IDLE.
- Latency: Start high in cycle 0 → COMPUTE in cycles 1..24 → Done in cycle 25. Busy is high in cycles 1..25.
- Multiply (shift-add):
  - 2*WIDTH-bit product register.
  - Each cycle, examine the multiplier LSB, conditionally add the multiplicand into the upper half, then shift right by 1.
  - MUL returns product[23:0]; MULH returns product[47:24].
  - All unsigned; no overflow flag.
- Divide (restoring):
  - Each cycle, shift {remainder, quotient} left by 1 and trial-subtract the divisor from the remainder using a WIDTH+1-bit subtraction.
  - If non-negative, keep the difference and set the quotient LSB to 1; else restore and set it to 0.
  - DIV returns the quotient; REM returns the remainder.
- Divide by zero: no special path; fixed latency still applies. The algorithm naturally yields quotient = 24'hFFFFFF and remainder = OperandA, and these are the required results.
- Start while Busy (including the DONE cycle): ignored; operands are not re-latched and the in-flight operation completes unchanged.
- Operand inputs may change after acceptance without effect.
- Start in the cycle immediately after DONE (IDLE) is accepted, giving back-to-back throughput of one op per 26 cycles.
- Reset mid-operation: next cycle is IDLE with all outputs at reset values. No ResultWrite pulse is ever emitted for an aborted operation.
- Reset has priority over Start in the same cycle.

Decomposition:
- Shared package cpu_pkg:
  - WIDTH = 24 and REG_ADDR_W = 4 constants.
  - Op encoding constants OP_MUL, OP_MULH, OP_DIV, OP_REM.
  - FSM state typedef {IDLE, COMPUTE, DONE}.
- One natural sub-module: mul_div_datapath (accumulators, shift/add/subtract, result select).
- FSM and counter stay in mul_div_unit.

Test Plan:
- Reset for 2 cycles, then Start MUL 5*7, DestReg = 8 → Busy in cycles 1..25; Done = ResultWrite = 1 only in cycle 25; Result = 35, ResultReg = 8; values held afterwards.
- MULH then MUL of 24'hFFFFFF*24'hFFFFFF (product 48'hFFFFFE000001) → MULH Result = 24'hFFFFFE; MUL Result = 24'h000001.
- DIV 100/7 → Result = 14; REM 100/7 → Result = 2; REM 6/7 → Result = 6.
- DIV 9/0 → Result = 24'hFFFFFF at cycle 25; REM 9/0 → Result = 9.
- Start MUL 3*4 (DestReg = 2), then Start DIV 50/5 (DestReg = 9) in cycles 5 and 25 → both ignored; Result = 12, ResultReg = 2. A new Start in cycle 26 is accepted.
- Start MUL 5*7, assert Reset in cycle 10 → Busy = 0 from cycle 11, no Done/ResultWrite at cycle 25, Result = 0. A subsequent Start produces a correct result.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 24-bit CPU execute-stage blocks.
package cpu_pkg;

  localparam int WIDTH      = 24;
  localparam int REG_ADDR_W = 4;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } fsmStateT;

endpackage

// File: rtl/mul_div_datapath.sv
// Shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator.
// Multiply keeps {product_hi, multiplier}; divide keeps {remainder, quotient}.
module mul_div_datapath
  import cpu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         finish,
  input  logic [1:0]   opIn,
  input  logic [W-1:0] operandA,
  input  logic [W-1:0] operandB,
  output logic [W-1:0] result
);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] accNext;
  logic [2*W-1:0] mulNext;
  logic [2*W-1:0] divNext;
  logic [W-1:0]   aQ;
  logic [W-1:0]   bQ;
  logic [1:0]     opQ;
  logic [W:0]     sum;
  logic [W:0]     remShift;
  logic [W:0]     diff;
  logic           fits;
  logic [W-1:0]   selResult;

  always_comb begin
    sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, aQ} : '0);
    mulNext  = {sum, acc[W-1:1]};
    // The remainder can briefly need W+1 bits after the shift, before subtraction.
    remShift = acc[2*W-1:W-1];
    fits     = (remShift >= {1'b0, bQ});
    diff     = remShift - {1'b0, bQ};
    divNext  = fits ? {diff[W-1:0], acc[W-2:0], 1'b1}
                    : {remShift[W-1:0], acc[W-2:0], 1'b0};
    accNext  = opQ[1] ? divNext : mulNext;
  end

  always_comb begin
    selResult = accNext[W-1:0];
    case (opQ)
      OP_MUL:  selResult = accNext[W-1:0];
      OP_MULH: selResult = accNext[2*W-1:W];
      OP_DIV:  selResult = accNext[W-1:0];
      OP_REM:  selResult = accNext[2*W-1:W];
      default: selResult = accNext[W-1:0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc    <= '0;
      aQ     <= '0;
      bQ     <= '0;
      opQ    <= OP_MUL;
      result <= '0;
    end else begin
      if (load) begin
        aQ  <= operandA;
        bQ  <= operandB;
        opQ <= opIn;
        acc <= {{W{1'b0}}, (opIn[1] ? operandA : operandB)};
      end else if (step) begin
        acc <= accNext;
      end
      if (finish) begin
        result <= selResult;
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit with fixed WIDTH-cycle compute phase.
// Writes back {Result, ResultReg} with a one-cycle ResultWrite strobe.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH      = cpu_pkg::WIDTH,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [WIDTH-1:0]      OperandA,
  input  logic [WIDTH-1:0]      OperandB,
  input  logic [REG_ADDR_W-1:0] DestReg,
  output logic                  Busy,
  output logic                  Done,
  output logic [WIDTH-1:0]      Result,
  output logic [REG_ADDR_W-1:0] ResultReg,
  output logic                  ResultWrite
);

  localparam int CNT_W = $clog2(WIDTH);

  fsmStateT              state;
  fsmStateT              stateNext;
  logic [CNT_W-1:0]      counter;
  logic [REG_ADDR_W-1:0] destQ;
  logic                  load;
  logic                  step;
  logic                  finish;

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load      = 1'b1;
          stateNext = COMPUTE;
        end
      end
      COMPUTE: begin
        step = 1'b1;
        if (counter == '0) begin
          finish    = 1'b1;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      counter   <= '0;
      destQ     <= '0;
      ResultReg <= '0;
    end else begin
      state <= stateNext;
      if (load) begin
        counter <= CNT_W'(WIDTH - 1);
        destQ   <= DestReg;
      end else if (step && counter != '0) begin
        counter <= counter - 1'b1;
      end
      if (finish) begin
        ResultReg <= destQ;
      end
    end
  end

  assign Busy        = (state != IDLE);
  assign Done        = (state == DONE);
  assign ResultWrite = (state == DONE);

  mul_div_datapath #(.W(WIDTH)) uDatapath (
    .clock    (Clock),
    .reset    (Reset),
    .load     (load),
    .step     (step),
    .finish   (finish),
    .opIn     (Op),
    .operandA (OperandA),
    .operandB (OperandB),
    .result   (Result)
  );

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected write-backs queued at Start, popped on Done.
module tb_mul_div_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [23:0] OperandA;
  logic [23:0] OperandB;
  logic [3:0]  DestReg;
  logic        Busy;
  logic        Done;
  logic [23:0] Result;
  logic [3:0]  ResultReg;
  logic        ResultWrite;

  typedef struct {
    logic [23:0] data;
    logic [3:0]  dest;
  } sbEntryT;

  sbEntryT sbQueue[$];
  int      checkCount = 0;
  int      failCount  = 0;

  mul_div_unit dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Op          (Op),
    .OperandA    (OperandA),
    .OperandB    (OperandB),
    .DestReg     (DestReg),
    .Busy        (Busy),
    .Done        (Done),
    .Result      (Result),
    .ResultReg   (ResultReg),
    .ResultWrite (ResultWrite)
  );

  always #5 Clock = ~Clock;

  task automatic checkEq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] model(input logic [1:0] op, input logic [23:0] a,
                                        input logic [23:0] b);
    logic [47:0] p;
    p = {24'd0, a} * {24'd0, b};
    case (op)
      2'b00:   return p[23:0];
      2'b01:   return p[47:24];
      2'b10:   return (b == 24'd0) ? 24'hFFFFFF : a / b;
      default: return (b == 24'd0) ? a : a % b;
    endcase
  endfunction

  // Called at a falling edge; that cycle is cycle 0 of the operation.
  task automatic runOp(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b,
                       input logic [3:0] dest, input bit intrude, input int resetAt);
    sbEntryT exp;
    sbEntryT got;
    exp.data = model(op, a, b);
    exp.dest = dest;
    Start    = 1'b1;
    Op       = op;
    OperandA = a;
    OperandB = b;
    DestReg  = dest;
    if (resetAt == 0) sbQueue.push_back(exp);
    @(posedge Clock);
    @(negedge Clock);
    Start    = 1'b0;
    Op       = ~op;
    OperandA = 24'($urandom);
    OperandB = 24'($urandom);
    DestReg  = 4'($urandom);
    for (int cyc = 1; cyc <= 25; cyc++) begin
      checkEq("busy", {47'd0, Busy}, {47'd0, (resetAt == 0 || cyc <= resetAt)});
      checkEq("done", {47'd0, Done}, {47'd0, (resetAt == 0 && cyc == 25)});
      checkEq("write", {47'd0, ResultWrite}, {47'd0, (resetAt == 0 && cyc == 25)});
      if (Done) begin
        if (sbQueue.size() == 0) begin
          checkEq("sb_empty_on_done", 48'd1, 48'd0);
        end else begin
          got = sbQueue.pop_front();
          checkEq("result", {24'd0, Result}, {24'd0, got.data});
          checkEq("result_reg", {44'd0, ResultReg}, {44'd0, got.dest});
        end
      end else if (resetAt != 0 && cyc > resetAt) begin
        checkEq("abort_result", {24'd0, Result}, 48'd0);
        checkEq("abort_reg", {44'd0, ResultReg}, 48'd0);
      end
      if (intrude && (cyc == 5 || cyc == 25)) begin
        Start    = 1'b1;
        Op       = 2'b10;
        OperandA = 24'd50;
        OperandB = 24'd5;
        DestReg  = 4'd9;
      end
      Reset = (cyc == resetAt);
      @(posedge Clock);
      @(negedge Clock);
      Start = 1'b0;
      Reset = 1'b0;
    end
    checkEq("busy_after", {47'd0, Busy}, 48'd0);
    checkEq("done_after", {47'd0, Done}, 48'd0);
    if (resetAt == 0) begin
      checkEq("result_held", {24'd0, Result}, {24'd0, exp.data});
      checkEq("reg_held", {44'd0, ResultReg}, {44'd0, exp.dest});
    end
  endtask

  initial begin
    Reset    = 1'b1;
    Start    = 1'b0;
    Op       = 2'b00;
    OperandA = '0;
    OperandB = '0;
    DestReg  = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checkEq("rst_busy", {47'd0, Busy}, 48'd0);
    checkEq("rst_done", {47'd0, Done}, 48'd0);
    checkEq("rst_write", {47'd0, ResultWrite}, 48'd0);
    checkEq("rst_result", {24'd0, Result}, 48'd0);
    checkEq("rst_reg", {44'd0, ResultReg}, 48'd0);
    Reset = 1'b0;

    runOp(2'b00, 24'd5, 24'd7, 4'd8, 1'b0, 0);
    runOp(2'b01, 24'hFFFFFF, 24'hFFFFFF, 4'd1, 1'b0, 0);
    runOp(2'b00, 24'hFFFFFF, 24'hFFFFFF, 4'd3, 1'b0, 0);
    runOp(2'b10, 24'd100, 24'd7, 4'd4, 1'b0, 0);
    runOp(2'b11, 24'd100, 24'd7, 4'd5, 1'b0, 0);
    runOp(2'b11, 24'd6, 24'd7, 4'd6, 1'b0, 0);
    runOp(2'b10, 24'd9, 24'd0, 4'd7, 1'b0, 0);
    runOp(2'b11, 24'd9, 24'd0, 4'd10, 1'b0, 0);
    runOp(2'b00, 24'd3, 24'd4, 4'd2, 1'b1, 0);
    runOp(2'b10, 24'd50, 24'd5, 4'd9, 1'b0, 0);
    runOp(2'b00, 24'd5, 24'd7, 4'd8, 1'b0, 10);
    runOp(2'b00, 24'd5, 24'd7, 4'd11, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      runOp(2'($urandom), 24'($urandom), (i == 3) ? 24'd1 : 24'($urandom_range(1, 4095)),
            4'($urandom), 1'b0, 0);
    end

    checkEq("sb_drained", 48'(sbQueue.size()), 48'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
